cu_seq: RTL
===========

# cu_seq

Registered, parametrised control unit for the ID stage. It decodes mode/op_code/S/immediate into execute, memory, write-back and branch controls, and drives them from an ID/EX output register with valid/ready, stall and flush. It adds block transfers: mode 2'b11 LDM/STM emits one memory micro-op per register in a REGS-bit list. It also adds optional condition-code squashing.

## Interface
- REGS, 16, width of the block-transfer register list (power of two, ≥2); RW = $clog2(REGS)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- valid_in  in  1  instruction present at decode
- ready_out  out  1  = !busy && !stall; an instruction is accepted when valid_in && ready_out
- mode  in  2  instruction class
- op_code  in  4  data-processing opcode
- S  in  1  mode 0: update status; modes 1/3: 1 = load, 0 = store
- immediate  in  1  operand-2 is immediate
- cond  in  4  condition field (used only with COND_EXEC_EN)
- status  in  4  NZCV flags {N,Z,C,V}, sampled at acceptance
- reg_list  in  REGS  block-transfer register mask
- stall  in  1  hold output register, accept nothing
- flush  in  1  kill output register and any block transfer
- valid_out  out  1  output register holds a micro-op
- exe_command  out  4  ALU command
- mem_read, mem_write, wb_enable, is_immediate, B, update_status  out  1 each
- xfer_reg  out  RW  register index of the current block micro-op
- xfer_offset  out  RW+2  byte offset = 4 × ordinal of the micro-op within the transfer
- busy  out  1  block transfer in progress (FSM in BLOCK)

## Operation
- Decode, mode 0: wb=1, mem/B=0. MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011, SUB 0010→0100, SBC 0110→0101, AND 0000→0110, ORR 1100→0111, EOR 0001→1000.
- Mode 0 compares: CMP 1010→0100 with wb=0; TST 1000→0110 with wb=0.
- Mode 0 other opcodes: 0000 with wb=0. update_status=S, is_immediate=immediate.
- Mode 1: exe 0010. S=1: mem_read=1, wb=1. S=0: mem_write=1, wb=0.
- Mode 2: B=1, exe 0000, all other enables 0.
- Mode 3: exe 0010 per micro-op, read/write/wb as mode 1. update_status=0 for modes 1–3.
- Block transfer order: set bits of reg_list ascending. The k-th micro-op (k from 0) has xfer_offset=4k and xfer_reg=bit index. xfer_reg/xfer_offset are 0 for non-block ops.
- Empty reg_list: one NOP micro-op; valid_out=1, all enables 0.
- FSM IDLE: accepting a mode-3 op with ≥2 set bits emits the first micro-op and goes BLOCK, latching the remaining mask, S and the offset counter. Otherwise stays IDLE.
- FSM BLOCK: each non-stalled cycle emits the lowest remaining bit and clears it. Emitting the last bit returns to IDLE.
- Squash (condition fails): valid_out=1, exe 0000, every enable 0. For mode 3 the FSM does not enter BLOCK.
- Flush (highest priority): next edge valid_out=0, FSM→IDLE, remaining mask cleared, no acceptance that cycle.
- Stall: all outputs and FSM state hold; ready_out=0.
- Not accepted and not stalled: valid_out←0.

## Timing
- Reset: FSM=IDLE, valid_out=0, exe_command=0000, all 1-bit controls 0, xfer_reg=0, xfer_offset=0, busy=0.
- Latency: 1 cycle from acceptance to outputs.
- A k-register block op occupies k consecutive non-stalled output cycles; ready_out=0 for the k−1 cycles after acceptance.
- flush and stall together: flush wins.
- Reset asserted mid-transfer aborts it immediately and asynchronously.

## Configuration
- COND_EXEC_EN defined: cond is evaluated against status with ARM semantics.
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL 1110 and 1111 always execute.
  - A failing condition squashes the instruction.
- Undefined: cond and status are ignored; every instruction executes.

## Test plan
- Reset, then ADD mode 0 op 0100 S=1 → next cycle valid_out=1, exe 0010, wb=1, update_status=1.
- CMP op 1010 → exe 0100, wb=0.
- Mode 1 S=1 → mem_read=1, wb=1, exe 0010. Mode 1 S=0 → mem_write=1, wb=0.
- Mode 3 S=1, reg_list=16'h0029 → three micro-ops with xfer_reg 0/3/5 and offsets 0/4/8. ready_out=0 for 2 cycles. One stall in the middle repeats the current op.
- Mode 3 S=0, reg_list=16'h00F0, flush on the 2nd output cycle → valid_out=0 next edge, busy=0, next instruction accepted.
- With COND_EXEC_EN: MOV cond=0000 with status Z=0 → squashed (exe 0000, wb=0). Same op with Z=1 → exe 0001, wb=1.

Source files
------------

// File: rtl/cu_seq_if.sv
// rtl/cu_seq_if.sv - decode/ID-EX bus for cu_seq
//
// Groups the decode-side inputs and the ID/EX register outputs of cu_seq.
//   master : drives the instruction fields, valid_in, stall and flush;
//            observes ready_out, busy and the registered controls.
//   slave  : the control unit itself.
// REGS is the block-transfer register-list width; RW = $clog2(REGS).
interface cu_seq_if #(
    parameter int REGS = 16
);
    localparam int RW = $clog2(REGS);

    logic            valid_in;
    logic            ready_out;
    logic [1:0]      mode;
    logic [3:0]      op_code;
    logic            S;
    logic            immediate;
    logic [3:0]      cond;
    logic [3:0]      status;
    logic [REGS-1:0] reg_list;
    logic            stall;
    logic            flush;

    logic            valid_out;
    logic [3:0]      exe_command;
    logic            mem_read;
    logic            mem_write;
    logic            wb_enable;
    logic            is_immediate;
    logic            B;
    logic            update_status;
    logic [RW-1:0]   xfer_reg;
    logic [RW+1:0]   xfer_offset;
    logic            busy;

    modport master (
        output valid_in, mode, op_code, S, immediate, cond, status, reg_list,
               stall, flush,
        input  ready_out, valid_out, exe_command, mem_read, mem_write,
               wb_enable, is_immediate, B, update_status, xfer_reg,
               xfer_offset, busy
    );

    modport slave (
        input  valid_in, mode, op_code, S, immediate, cond, status, reg_list,
               stall, flush,
        output ready_out, valid_out, exe_command, mem_read, mem_write,
               wb_enable, is_immediate, B, update_status, xfer_reg,
               xfer_offset, busy
    );
endinterface

// File: rtl/cu_seq.sv
// rtl/cu_seq.sv - registered ID-stage control unit with LDM/STM sequencing
//
// Decodes mode/op_code/S/immediate into EX/MEM/WB/branch controls held in an
// ID/EX output register. Mode 3 expands a register list into one memory
// micro-op per set bit, lowest index first, with byte offset 4*ordinal.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - cu_seq_if.slave (decode inputs, valid/ready, stall, flush,
//          registered controls, xfer_reg/xfer_offset, busy)
// Optional feature macro: COND_EXEC_EN (ARM condition-code squashing).
module cu_seq #(
    parameter int REGS = 16
) (
    input  logic     clk,
    input  logic     rst,
    cu_seq_if.slave  bus
);
    localparam int RW = $clog2(REGS);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BLOCK = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [REGS-1:0] mask_q, mask_d;
    logic            s_q, s_d;
    logic [RW-1:0]   cnt_q, cnt_d;

    logic            valid_q, valid_d;
    logic [3:0]      exe_q, exe_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;
    logic            wb_q, wb_d;
    logic            imm_q, imm_d;
    logic            b_q, b_d;
    logic            us_q, us_d;
    logic [RW-1:0]   xfer_reg_q, xfer_reg_d;
    logic [RW+1:0]   xfer_offset_q, xfer_offset_d;

    logic            cond_ok;

    function automatic logic [RW-1:0] lowest_idx(input logic [REGS-1:0] m);
        logic [RW-1:0] r;
        r = '0;
        for (int i = REGS - 1; i >= 0; i--) begin
            if (m[i]) r = RW'(i);
        end
        return r;
    endfunction

`ifdef COND_EXEC_EN
    logic n_f, z_f, c_f, v_f;
    assign {n_f, z_f, c_f, v_f} = bus.status;
    always_comb begin
        cond_ok = 1'b1;
        case (bus.cond)
            4'b0000: cond_ok = z_f;
            4'b0001: cond_ok = !z_f;
            4'b0010: cond_ok = c_f;
            4'b0011: cond_ok = !c_f;
            4'b0100: cond_ok = n_f;
            4'b0101: cond_ok = !n_f;
            4'b0110: cond_ok = v_f;
            4'b0111: cond_ok = !v_f;
            4'b1000: cond_ok = c_f && !z_f;
            4'b1001: cond_ok = !c_f || z_f;
            4'b1010: cond_ok = (n_f == v_f);
            4'b1011: cond_ok = (n_f != v_f);
            4'b1100: cond_ok = !z_f && (n_f == v_f);
            4'b1101: cond_ok = z_f || (n_f != v_f);
            default: cond_ok = 1'b1;
        endcase
    end
`else
    logic unused_cond;
    assign unused_cond = ^{bus.cond, bus.status};
    assign cond_ok     = 1'b1;
`endif

    assign bus.busy      = (state_q == BLOCK);
    assign bus.ready_out = (state_q == IDLE) && !bus.stall;

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        s_d           = s_q;
        cnt_d         = cnt_q;
        valid_d       = valid_q;
        exe_d         = exe_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        wb_d          = wb_q;
        imm_d         = imm_q;
        b_d           = b_q;
        us_d          = us_q;
        xfer_reg_d    = xfer_reg_q;
        xfer_offset_d = xfer_offset_q;

        if (bus.flush) begin
            valid_d = 1'b0;
            state_d = IDLE;
            mask_d  = '0;
        end else if (bus.stall) begin
            // everything holds
        end else if (state_q == BLOCK) begin
            valid_d       = 1'b1;
            exe_d         = 4'b0010;
            mem_read_d    = s_q;
            mem_write_d   = !s_q;
            wb_d          = s_q;
            imm_d         = 1'b0;
            b_d           = 1'b0;
            us_d          = 1'b0;
            xfer_reg_d    = lowest_idx(mask_q);
            xfer_offset_d = {cnt_q, 2'b00};
            mask_d        = mask_q & (mask_q - 1'b1);
            cnt_d         = cnt_q + RW'(1);
            if (mask_d == '0) state_d = IDLE;
        end else if (bus.valid_in) begin
            // Start from an all-zero micro-op; a failed condition leaves it
            // that way, which is exactly the squashed form.
            valid_d       = 1'b1;
            exe_d         = 4'b0000;
            mem_read_d    = 1'b0;
            mem_write_d   = 1'b0;
            wb_d          = 1'b0;
            imm_d         = 1'b0;
            b_d           = 1'b0;
            us_d          = 1'b0;
            xfer_reg_d    = '0;
            xfer_offset_d = '0;
            if (cond_ok) begin
                case (bus.mode)
                    2'd0: begin
                        us_d  = bus.S;
                        imm_d = bus.immediate;
                        wb_d  = 1'b1;
                        case (bus.op_code)
                            4'b1101: exe_d = 4'b0001;
                            4'b1111: exe_d = 4'b1001;
                            4'b0100: exe_d = 4'b0010;
                            4'b0101: exe_d = 4'b0011;
                            4'b0010: exe_d = 4'b0100;
                            4'b0110: exe_d = 4'b0101;
                            4'b0000: exe_d = 4'b0110;
                            4'b1100: exe_d = 4'b0111;
                            4'b0001: exe_d = 4'b1000;
                            4'b1010: begin exe_d = 4'b0100; wb_d = 1'b0; end
                            4'b1000: begin exe_d = 4'b0110; wb_d = 1'b0; end
                            default: begin exe_d = 4'b0000; wb_d = 1'b0; end
                        endcase
                    end
                    2'd1: begin
                        exe_d       = 4'b0010;
                        imm_d       = bus.immediate;
                        mem_read_d  = bus.S;
                        mem_write_d = !bus.S;
                        wb_d        = bus.S;
                    end
                    2'd2: b_d = 1'b1;
                    default: begin
                        // Empty list stays an all-zero NOP micro-op.
                        if (bus.reg_list != '0) begin
                            exe_d       = 4'b0010;
                            mem_read_d  = bus.S;
                            mem_write_d = !bus.S;
                            wb_d        = bus.S;
                            xfer_reg_d  = lowest_idx(bus.reg_list);
                            // More than one bit set: remaining bits go to BLOCK.
                            if ((bus.reg_list & (bus.reg_list - 1'b1)) != '0) begin
                                state_d = BLOCK;
                                mask_d  = bus.reg_list & (bus.reg_list - 1'b1);
                                s_d     = bus.S;
                                cnt_d   = RW'(1);
                            end
                        end
                    end
                endcase
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            mask_q        <= '0;
            s_q           <= 1'b0;
            cnt_q         <= '0;
            valid_q       <= 1'b0;
            exe_q         <= 4'b0000;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            wb_q          <= 1'b0;
            imm_q         <= 1'b0;
            b_q           <= 1'b0;
            us_q          <= 1'b0;
            xfer_reg_q    <= '0;
            xfer_offset_q <= '0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            s_q           <= s_d;
            cnt_q         <= cnt_d;
            valid_q       <= valid_d;
            exe_q         <= exe_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            wb_q          <= wb_d;
            imm_q         <= imm_d;
            b_q           <= b_d;
            us_q          <= us_d;
            xfer_reg_q    <= xfer_reg_d;
            xfer_offset_q <= xfer_offset_d;
        end
    end

    assign bus.valid_out     = valid_q;
    assign bus.exe_command   = exe_q;
    assign bus.mem_read      = mem_read_q;
    assign bus.mem_write     = mem_write_q;
    assign bus.wb_enable     = wb_q;
    assign bus.is_immediate  = imm_q;
    assign bus.B             = b_q;
    assign bus.update_status = us_q;
    assign bus.xfer_reg      = xfer_reg_q;
    assign bus.xfer_offset   = xfer_offset_q;
endmodule
